// File: rtl/addsub_chunked_alu.sv
`default_nettype none
// ============================================================================
// Module      : addsub_chunked_alu
// Description : Multi-cycle two's-complement adder/subtractor. One operation
//               is accepted over a valid/ready handshake. It is then processed
//               CHUNK bits per clock, LSB chunk first, with the ripple carry
//               held in a register between chunks. The result and its flags
//               are returned over a second valid/ready handshake.
//
// Ports       : clk        - rising-edge clock
//               rst_n      - asynchronous active-low reset
//               in_valid   - a/b/sub/cin valid
//               in_ready   - block is idle and can accept an operation
//               a, b       - WIDTH-bit operands
//               sub        - 0 = add, 1 = subtract
//               cin        - carry-in (add) or borrow-in (subtract)
//               out_valid  - s and flags valid
//               out_ready  - consumer accepts the result
//               s          - WIDTH-bit result
//               cout       - raw carry out of MSB (subtract: 1 = no borrow)
//               overflow   - signed overflow
//               zero       - s == 0
//               negative   - s[WIDTH-1]
//               busy       - operation in flight or result pending
//
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_chunked_alu #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   part_q, part_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;
    logic               neg_q, neg_d;

    logic [CHUNK:0]       w_sum;
    logic [WIDTH+CHUNK-1:0] w_part_cat;
    logic [WIDTH-1:0]     w_part_next;
    logic                 w_msb_cin;

    // Operands are shifted right one chunk per cycle, so the chunk being
    // worked on is always the low CHUNK bits of a_q/b_q.
    always_comb begin
        w_sum       = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, carry_q};
        // New chunk enters at the top; after NCHUNK cycles the first chunk
        // has reached bit 0 and the partial register holds the full result.
        w_part_cat  = {w_sum[CHUNK-1:0], part_q};
        w_part_next = w_part_cat[WIDTH+CHUNK-1:CHUNK];
        // Sum bit = a ^ b ^ carry-in, so the carry into the top bit of the
        // chunk is recovered from the sum bit and the two operand bits.
        w_msb_cin   = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ w_sum[CHUNK-1];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        part_d  = part_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        neg_d   = neg_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    // Subtract is a + ~b + ~cin.
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub ? ~cin : cin;
                    cnt_d   = '0;
                    part_d  = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = w_sum[CHUNK];
                part_d  = w_part_next;
                if (cnt_q == LAST_CNT) begin
                    s_d     = w_part_next;
                    cout_d  = w_sum[CHUNK];
                    ovf_d   = w_msb_cin ^ w_sum[CHUNK];
                    zero_d  = ~|w_part_next;
                    neg_d   = w_part_next[WIDTH-1];
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            part_q  <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            part_q  <= part_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign s         = s_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;
    assign negative  = neg_q;

endmodule
`default_nettype wire

// File: tb/tb_addsub_chunked_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_addsub_chunked_alu
// Description : Self-checking bench for addsub_chunked_alu. Four instances
//               (CHUNK = 4, 1, 8, 16 at WIDTH = 16) share clock and reset;
//               each has its own handshake and operand signals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_chunked_alu;

    logic        clk;
    logic        rst_n;
    logic        in_valid_v  [4];
    logic        in_ready_v  [4];
    logic [15:0] a_v         [4];
    logic [15:0] b_v         [4];
    logic        sub_v       [4];
    logic        cin_v       [4];
    logic        out_valid_v [4];
    logic        out_ready_v [4];
    logic [15:0] s_v         [4];
    logic        cout_v      [4];
    logic        ov_v        [4];
    logic        zero_v      [4];
    logic        neg_v       [4];
    logic        busy_v      [4];

    // Last completed result per instance: {s, cout, overflow, zero, negative}
    logic [19:0] prev_r [4];

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        addsub_chunked_alu #(
            .WIDTH (16),
            .CHUNK ((g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 8 : 16)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid_v[g]),
            .in_ready  (in_ready_v[g]),
            .a         (a_v[g]),
            .b         (b_v[g]),
            .sub       (sub_v[g]),
            .cin       (cin_v[g]),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready_v[g]),
            .s         (s_v[g]),
            .cout      (cout_v[g]),
            .overflow  (ov_v[g]),
            .zero      (zero_v[g]),
            .negative  (neg_v[g]),
            .busy      (busy_v[g])
        );
    end

    function automatic int latency_of(int k);
        case (k)
            0:       return 4;
            1:       return 16;
            2:       return 2;
            default: return 1;
        endcase
    endfunction

    // Reference: whole-word arithmetic and sign-rule overflow.
    function automatic logic [19:0] model(logic [15:0] av, logic [15:0] bv,
                                          logic sv, logic cv);
        logic [15:0] bb;
        logic        ci;
        logic [16:0] full;
        logic [15:0] rs;
        logic        ov;
        bb   = sv ? ~bv : bv;
        ci   = sv ? ~cv : cv;
        full = {1'b0, av} + {1'b0, bb} + {16'd0, ci};
        rs   = full[15:0];
        ov   = (av[15] == bb[15]) && (rs[15] != av[15]);
        return {rs, full[16], ov, (rs == 16'd0), rs[15]};
    endfunction

    function automatic logic [19:0] observed(int k);
        return {s_v[k], cout_v[k], ov_v[k], zero_v[k], neg_v[k]};
    endfunction

    // Full transaction on instance k: accept, watch the run, hold the result
    // for 'stall' cycles (optionally wiggling inputs), then release.
    task automatic run_op(int k, logic [15:0] av, logic [15:0] bv, logic sv,
                          logic cv, int stall, bit toggle);
        logic [19:0] exp_r;
        int          lat;
        int          busy_cnt;
        int          guard;
        exp_r = model(av, bv, sv, cv);

        @(negedge clk);
        a_v[k] = av; b_v[k] = bv; sub_v[k] = sv; cin_v[k] = cv;
        in_valid_v[k] = 1'b1;
        guard = 0;
        while (!in_ready_v[k] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (in_ready_v[k] !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_ready k=%0d: in_ready=%b required 1", k, in_ready_v[k]);
        end
        @(posedge clk);
        #1;
        // Scramble inputs after acceptance; the captured operands must win.
        in_valid_v[k] = 1'b0;
        a_v[k] = 16'($urandom); b_v[k] = 16'($urandom);
        sub_v[k] = 1'($urandom); cin_v[k] = 1'($urandom);

        lat = 0;
        busy_cnt = 0;
        while (!out_valid_v[k] && lat < 40) begin
            if (busy_v[k]) busy_cnt++;
            n_checks++;
            if (observed(k) !== prev_r[k]) begin
                n_fail++;
                $display("FAIL hold_during_run k=%0d: got %h required %h", k, observed(k), prev_r[k]);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        n_checks++;
        if (lat !== latency_of(k)) begin
            n_fail++;
            $display("FAIL latency k=%0d: got %0d required %0d", k, lat, latency_of(k));
        end
        n_checks++;
        if (observed(k) !== exp_r) begin
            n_fail++;
            $display("FAIL result k=%0d a=%h b=%h sub=%b cin=%b: got %h required %h",
                     k, av, bv, sv, cv, observed(k), exp_r);
        end

        for (int i = 0; i < stall; i++) begin
            if (busy_v[k]) busy_cnt++;
            @(negedge clk);
            if (toggle) begin
                a_v[k] = ~a_v[k]; b_v[k] = b_v[k] + 16'd1;
                in_valid_v[k] = ~in_valid_v[k];
            end
            @(posedge clk);
            #1;
            n_checks++;
            if ({out_valid_v[k], in_ready_v[k], observed(k)} !== {2'b10, exp_r}) begin
                n_fail++;
                $display("FAIL backpressure k=%0d: ov/ir/res=%b%b/%h required 10/%h",
                         k, out_valid_v[k], in_ready_v[k], observed(k), exp_r);
            end
        end
        if (busy_v[k]) busy_cnt++;

        @(negedge clk);
        in_valid_v[k] = 1'b0;
        out_ready_v[k] = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid_v[k], in_ready_v[k], busy_v[k], observed(k)} !== {3'b010, exp_r}) begin
            n_fail++;
            $display("FAIL release k=%0d: ov/ir/busy/res=%b%b%b/%h required 010/%h",
                     k, out_valid_v[k], in_ready_v[k], busy_v[k], observed(k), exp_r);
        end
        n_checks++;
        if (busy_cnt !== latency_of(k) + 1 + stall) begin
            n_fail++;
            $display("FAIL busy_cycles k=%0d: got %0d required %0d", k, busy_cnt,
                     latency_of(k) + 1 + stall);
        end
        @(negedge clk);
        out_ready_v[k] = 1'b0;
        prev_r[k] = exp_r;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid_v[k] = 1'b0; out_ready_v[k] = 1'b0;
            a_v[k] = '0; b_v[k] = '0; sub_v[k] = 1'b0; cin_v[k] = 1'b0;
            prev_r[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({in_ready_v[k], out_valid_v[k], busy_v[k], observed(k)} !== {3'b100, 20'd0}) begin
                n_fail++;
                $display("FAIL reset_state k=%0d: ir/ov/busy/res=%b%b%b/%h required 100/00000",
                         k, in_ready_v[k], out_valid_v[k], busy_v[k], observed(k));
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add_basic();
        run_op(0, 16'h0003, 16'h0004, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_subtract();
        run_op(0, 16'h0005, 16'h0007, 1'b1, 1'b0, 0, 1'b0);
        run_op(0, 16'h8000, 16'h0001, 1'b1, 1'b0, 0, 1'b0);
    endtask

    task automatic test_add_overflow();
        run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        run_op(0, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 0, 1'b0);
    endtask

    task automatic test_back_pressure();
        run_op(0, 16'h1234, 16'h1234, 1'b1, 1'b0, 3, 1'b1);
    endtask

    task automatic test_reset_mid_run();
        run_op(0, 16'h00F3, 16'h0104, 1'b0, 1'b1, 0, 1'b0);
        @(negedge clk);
        a_v[0] = 16'h4000; b_v[0] = 16'h4000; sub_v[0] = 1'b0; cin_v[0] = 1'b0;
        in_valid_v[0] = 1'b1;
        @(posedge clk);          // accept: first RUN cycle begins
        #1;
        in_valid_v[0] = 1'b0;
        @(posedge clk);          // second RUN cycle begins
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready_v[0], out_valid_v[0], busy_v[0], observed(0)} !== {3'b100, 20'd0}) begin
            n_fail++;
            $display("FAIL reset_mid_run: ir/ov/busy/res=%b%b%b/%h required 100/00000",
                     in_ready_v[0], out_valid_v[0], busy_v[0], observed(0));
        end
        for (int k = 0; k < 4; k++) prev_r[k] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({in_ready_v[0], out_valid_v[0]} !== 2'b10) begin
            n_fail++;
            $display("FAIL after_reset_idle: ir/ov=%b%b required 10", in_ready_v[0], out_valid_v[0]);
        end
        run_op(0, 16'h0001, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_chunk_sweep();
        for (int k = 0; k < 4; k++) begin
            run_op(k, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
            run_op(k, 16'h8000, 16'h0001, 1'b1, 1'b0, 0, 1'b0);
            for (int n = 0; n < 25; n++) begin
                run_op(k, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                       int'($urandom_range(0, 3)), 1'($urandom));
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_subtract();
        test_add_overflow();
        test_back_pressure();
        test_reset_mid_run();
        test_chunk_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
